// File: rtl/vp_gfx_pixel_serializer_if.sv
`default_nettype none
// ---------------------------------------------------------------------
// vp_gfx_pixel_serializer_if : cell-load and pixel-output bundle   rev 1.0
// ---------------------------------------------------------------------
interface vp_gfx_pixel_serializer_if;
  logic        flush;
  logic        cell_load;
  logic [15:0] gfx_bitmap;
  logic [3:0]  gfx_foreground;
  logic [3:0]  gfx_background;
  logic        enable;
  logic        double_width;
  logic        cell_ready;
  logic [3:0]  pixel_color;
  logic        pixel_valid;
  logic        overflow;

  modport master (
    output flush, cell_load, gfx_bitmap, gfx_foreground, gfx_background,
           enable, double_width,
    input  cell_ready, pixel_color, pixel_valid, overflow
  );

  modport slave (
    input  flush, cell_load, gfx_bitmap, gfx_foreground, gfx_background,
           enable, double_width,
    output cell_ready, pixel_color, pixel_valid, overflow
  );
endinterface
`default_nettype wire

// File: rtl/vp_gfx_pixel_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------
// vp_gfx_pixel_serializer : 16-pixel cell row to 4-bit pixel stream  rev 1.0
// ---------------------------------------------------------------------
module vp_gfx_pixel_serializer (
  input  wire                          clk,
  input  wire                          reset,
  vp_gfx_pixel_serializer_if.slave     bus
);

  localparam logic [5:0] C_CNT_SINGLE = 6'd16;
  localparam logic [5:0] C_CNT_DOUBLE = 6'd32;

  logic [15:0] hold_bitmap_q, hold_bitmap_d;
  logic [3:0]  hold_fg_q,     hold_fg_d;
  logic [3:0]  hold_bg_q,     hold_bg_d;
  logic        hold_dw_q,     hold_dw_d;
  logic        hold_full_q,   hold_full_d;

  logic [15:0] shift_q,       shift_d;
  logic [3:0]  act_fg_q,      act_fg_d;
  logic [3:0]  act_bg_q,      act_bg_d;
  logic        act_dw_q,      act_dw_d;
  logic [5:0]  cnt_q,         cnt_d;

  logic [3:0]  pixel_color_q, pixel_color_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        overflow_q,    overflow_d;

  always_comb begin
    hold_bitmap_d = hold_bitmap_q;
    hold_fg_d     = hold_fg_q;
    hold_bg_d     = hold_bg_q;
    hold_dw_d     = hold_dw_q;
    hold_full_d   = hold_full_q;
    shift_d       = shift_q;
    act_fg_d      = act_fg_q;
    act_bg_d      = act_bg_q;
    act_dw_d      = act_dw_q;
    cnt_d         = cnt_q;
    pixel_color_d = pixel_color_q;
    pixel_valid_d = pixel_valid_q;
    overflow_d    = overflow_q;

    if (bus.flush) begin
      hold_full_d   = 1'b0;
      cnt_d         = 6'd0;
      pixel_valid_d = 1'b0;
      pixel_color_d = 4'd0;
      // The holding buffer is empty after the clear, so a coincident load always lands.
      if (bus.cell_load) begin
        hold_bitmap_d = bus.gfx_bitmap & {16{bus.enable}};
        hold_fg_d     = bus.gfx_foreground;
        hold_bg_d     = bus.gfx_background;
        hold_dw_d     = bus.double_width;
        hold_full_d   = 1'b1;
      end
    end else begin
      if (cnt_q != 6'd0) begin
        pixel_color_d = shift_q[15] ? act_fg_q : act_bg_q;
        pixel_valid_d = 1'b1;
        cnt_d         = cnt_q - 6'd1;
        // In double width the count runs 32..1, so odd counts close each pixel pair.
        if (!act_dw_q || cnt_q[0]) begin
          shift_d = {shift_q[14:0], 1'b0};
        end
      end else begin
        pixel_valid_d = 1'b0;
        pixel_color_d = 4'd0;
      end

      if ((cnt_q <= 6'd1) && hold_full_q) begin
        shift_d     = hold_bitmap_q;
        act_fg_d    = hold_fg_q;
        act_bg_d    = hold_bg_q;
        act_dw_d    = hold_dw_q;
        cnt_d       = hold_dw_q ? C_CNT_DOUBLE : C_CNT_SINGLE;
        hold_full_d = 1'b0;
      end

      // Acceptance looks at the registered flag only, so a load on the transfer edge is dropped.
      if (bus.cell_load) begin
        if (hold_full_q) begin
          overflow_d = 1'b1;
        end else begin
          hold_bitmap_d = bus.gfx_bitmap & {16{bus.enable}};
          hold_fg_d     = bus.gfx_foreground;
          hold_bg_d     = bus.gfx_background;
          hold_dw_d     = bus.double_width;
          hold_full_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_bitmap_q <= 16'd0;
      hold_fg_q     <= 4'd0;
      hold_bg_q     <= 4'd0;
      hold_dw_q     <= 1'b0;
      hold_full_q   <= 1'b0;
      shift_q       <= 16'd0;
      act_fg_q      <= 4'd0;
      act_bg_q      <= 4'd0;
      act_dw_q      <= 1'b0;
      cnt_q         <= 6'd0;
      pixel_color_q <= 4'd0;
      pixel_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      hold_bitmap_q <= hold_bitmap_d;
      hold_fg_q     <= hold_fg_d;
      hold_bg_q     <= hold_bg_d;
      hold_dw_q     <= hold_dw_d;
      hold_full_q   <= hold_full_d;
      shift_q       <= shift_d;
      act_fg_q      <= act_fg_d;
      act_bg_q      <= act_bg_d;
      act_dw_q      <= act_dw_d;
      cnt_q         <= cnt_d;
      pixel_color_q <= pixel_color_d;
      pixel_valid_q <= pixel_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.cell_ready  = ~hold_full_q;
  assign bus.pixel_color = pixel_color_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: doc/vp_gfx_pixel_serializer.md
# vp_gfx_pixel_serializer

Downstream stage of the graphics bitmap expander. Accepts one pre-expanded 16-pixel character-cell row (bitmap plus foreground/background colour indices) per load and shifts it out as one 4-bit colour index per clock, optionally doubling each pixel horizontally. A one-entry holding buffer lets the next cell be accepted while the current one shifts, so back-to-back cells stream with no gap. Output feeds the palette/video mixer.

## Interface
- No parameters. Cell width is fixed at 16 pixels.
- clk  in  1  pixel clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous line-start clear of buffered and active cells
- cell_load  in  1  one-cycle strobe: cell inputs valid this cycle
- gfx_bitmap  in  16  cell row, bit 15 = leftmost pixel
- gfx_foreground  in  4  colour index for 1 bits
- gfx_background  in  4  colour index for 0 bits
- enable  in  1  cell graphics enabled; 0 forces bitmap to all zeros
- double_width  in  1  1 = each pixel emitted for 2 clocks (32-clock cell)
- cell_ready  out  1  holding buffer empty; load accepted this cycle
- pixel_color  out  4  registered pixel colour index
- pixel_valid  out  1  registered; pixel_color is a real pixel
- overflow  out  1  sticky: load arrived while cell_ready = 0

## Operation
- State: holding buffer {bitmap, fg, bg, dw, full}; active register {shift[15:0], fg, bg, dw, cnt[5:0]}; cnt = output clocks remaining, 0 = empty.
- Load: cell_load with hold_full = 0 -> holding captures inputs (bitmap ANDed with enable), full <= 1, double_width latched per cell.
- Load with hold_full = 1 -> cell dropped, holding unchanged, overflow <= 1 (stays until reset; flush does not clear it).
- cell_ready = ~hold_full (registered state, no combinational path from cell_load).
- Emit, each edge with cnt != 0: pixel_color <= shift[15] ? fg : bg; pixel_valid <= 1; cnt <= cnt - 1.
- Shift: dw = 0 -> shift left every emit; dw = 1 -> shift left only on emits where cnt is odd (cnt counts 32..1).
- Edge with cnt = 0: pixel_valid <= 0, pixel_color <= 0.
- Transfer: on an edge where cnt is 0 or 1 and hold_full = 1, active <= holding, cnt <= 16 or 32, hold_full <= 0. With cnt = 1 the last pixel of the old cell is emitted on the same edge (seamless).
- Transfer and a new load on the same edge: not accepted (cell_ready was 0); overflow set.
- flush: clears hold_full and cnt, drives pixel_valid <= 0 and pixel_color <= 0. cell_load on the same edge is accepted into holding after the clear.
- Priority: reset > flush > transfer/emit > load.

## Timing
- Reset values: cell_ready = 1, pixel_color = 0, pixel_valid = 0, overflow = 0; buffers empty, cnt = 0.
- Latency with pipeline idle: cell_load sampled at edge E0 -> holding. E1 -> active. E2 -> first pixel, so pixel_valid = 1 after E2.
- Cell duration: exactly 16 (dw = 0) or 32 (dw = 1) consecutive pixel_valid cycles.
- Continuous stream: cell_ready rises after the transfer edge. A load any time before the active cell's cnt = 1 edge yields zero gap between cells.
- Reset asserted mid-cell: all outputs reach reset values immediately (async). The first post-reset load follows the idle latency above.

## Test plan
- Reset/idle: assert reset mid-stream -> pixel_valid = 0, pixel_color = 0, cell_ready = 1, overflow = 0 immediately. No activity without a load.
- Single cell: load bitmap 0xA5F0, fg = 0xC, bg = 0x3, dw = 0 at E0 -> E2..E17 emit C,3,C,3,3,C,3,C,C,C,C,C,3,3,3,3. pixel_valid = 0 from E18.
- Double width + disable: load 0x8001, fg = 7, bg = 1, dw = 1 -> 32 pixels: 7,7, then 28×1, then 7,7. Repeat with enable = 0 -> 32×1.
- Back-to-back: load 0xFFFF then 0x0000 (fg = F, bg = 0) while the first shifts -> 16×F immediately followed by 16×0, pixel_valid continuous for 32 cycles.
- Overflow: fill active and holding, then pulse a third load -> overflow = 1 and the third cell is never emitted. Overflow persists through flush and clears only on reset.
- Flush with load: mid-cell flush coinciding with a load of 0x8000 -> next edge pixel_valid = 0. The new cell's first pixel (fg) appears 2 edges after the flush edge.
